// File: rtl/dlfloat_pkg.sv
// dlfloat_pkg
//   Shared DLFloat (1 sign / 6 exponent / 9 mantissa) definitions for the
//   adder arbiter slice: format constants, the word type and the arbiter
//   FSM state encoding.
package dlfloat_pkg;

    localparam int DLF_W     = 16;
    localparam int DLF_EXP_W = 6;
    localparam int DLF_MAN_W = 9;
    localparam int DLF_BIAS  = 31;

    typedef logic [DLF_W-1:0] dlf_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dlf_rr_arbiter2.sv
// dlf_rr_arbiter2
//   Two-way combinational grant. A lone valid is always granted; on a tie
//   the requester that did not win last time is granted.
//   Optional macro DLF_ARB_FIXED_PRIO_EN: requester 0 always wins ties and
//   last_grant is ignored.
// Ports
//   valid[1:0]  in   request valids
//   last_grant  in   index of the previously granted requester
//   grant[1:0]  out  one-hot or zero grant
module dlf_rr_arbiter2
    import dlfloat_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

`ifdef DLF_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
`ifdef DLF_ARB_FIXED_PRIO_EN
                grant = 2'b01;
`else
                grant = last_grant ? 2'b01 : 2'b10;
`endif
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dlfloat_add_arbiter.sv
// dlfloat_add_arbiter
//   Shares one external combinational DLFloat adder between two requesters.
//   Operands are registered onto add_a/add_b, held for ADD_LAT cycles, then
//   add_sum is captured into resp_sum and presented to the owning requester
//   until it is taken. One transaction in flight at a time.
//   Optional macro DLF_ARB_FIXED_PRIO_EN (see dlf_rr_arbiter2): fixed
//   priority to requester 0 on ties instead of round-robin.
// Parameters
//   ADD_LAT  cycles add_a/add_b are held before add_sum is sampled (1..15)
//   DW       word width, fixed at 16
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   req{0,1}_valid/ready/a/b    operand request channels
//   resp{0,1}_valid/ready       result response channels
//   resp_sum                    result shared by both response channels
//   add_a, add_b, add_sum       interface to the shared adder
//   busy                        high whenever the FSM is not idle
//
// state | meaning
// IDLE  | waiting for a request, readies follow the arbiter grant
// WAIT  | operands on the adder, counting down settle time
// RESP  | sum captured, waiting for owner's resp_ready
module dlfloat_add_arbiter
    import dlfloat_pkg::*;
#(
    parameter int ADD_LAT = 1,
    parameter int DW      = DLF_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    output logic          resp0_valid,
    input  logic          resp0_ready,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    output logic          resp1_valid,
    input  logic          resp1_ready,
    output logic [DW-1:0] resp_sum,
    output logic [DW-1:0] add_a,
    output logic [DW-1:0] add_b,
    input  logic [DW-1:0] add_sum,
    output logic          busy
);

    localparam logic [3:0] CNT_INIT = 4'(ADD_LAT - 1);

    arb_state_t state;
    logic [3:0] cnt;
    logic       owner;
    logic       last_grant;
    logic [1:0] grant;
    logic       idle;

    dlf_rr_arbiter2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign idle = (state == IDLE);

    // Ready is suppressed during reset so no handshake is ever seen on an
    // edge that the reset discards.
    assign req0_ready = grant[0] & idle & ~rst;
    assign req1_ready = grant[1] & idle & ~rst;
    assign busy       = ~idle;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            add_a       <= '0;
            add_b       <= '0;
            resp_sum    <= '0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        owner      <= grant[1];
                        last_grant <= grant[1];
                        add_a      <= grant[1] ? req1_a : req0_a;
                        add_b      <= grant[1] ? req1_b : req0_b;
                        cnt        <= CNT_INIT;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        resp_sum <= add_sum;
                        if (owner) resp1_valid <= 1'b1;
                        else       resp0_valid <= 1'b1;
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (owner ? resp1_ready : resp0_ready) begin
                        resp0_valid <= 1'b0;
                        resp1_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dlfloat_add_arbiter.sv
module tb_dlfloat_add_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // ADD_LAT=1 instance
    logic        r0v, r0r, s0v, s0r, r1v, r1r, s1v, s1r, busy;
    logic [15:0] r0a, r0b, r1a, r1b, sum, aa, ab, asum;
    assign asum = aa + ab;

    // ADD_LAT=4 instance with a glitching stub adder
    logic        q0v, q0r, qs0v, qs0r, q1v, q1r, qs1v, qs1r, qbusy, glitch;
    logic [15:0] q0a, q0b, q1a, q1b, qsum, qa, qb, qasum;
    assign qasum = (qa + qb) ^ (glitch ? 16'h5A5A : 16'h0000);

    dlfloat_add_arbiter #(.ADD_LAT(1)) u1 (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_ready(r0r), .req0_a(r0a), .req0_b(r0b),
        .resp0_valid(s0v), .resp0_ready(s0r),
        .req1_valid(r1v), .req1_ready(r1r), .req1_a(r1a), .req1_b(r1b),
        .resp1_valid(s1v), .resp1_ready(s1r),
        .resp_sum(sum), .add_a(aa), .add_b(ab), .add_sum(asum), .busy(busy)
    );

    dlfloat_add_arbiter #(.ADD_LAT(4)) u4 (
        .clk(clk), .rst(rst),
        .req0_valid(q0v), .req0_ready(q0r), .req0_a(q0a), .req0_b(q0b),
        .resp0_valid(qs0v), .resp0_ready(qs0r),
        .req1_valid(q1v), .req1_ready(q1r), .req1_a(q1a), .req1_b(q1b),
        .resp1_valid(qs1v), .resp1_ready(qs1r),
        .resp_sum(qsum), .add_a(qa), .add_b(qb), .add_sum(qasum), .busy(qbusy)
    );

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [16:0] sb[$];      // {requester id, expected sum}
    int          gq[$];      // granted requester per accept
    int          gc[$];      // cycle of each accept
    bit          s1_seen;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_resp(input logic id);
        logic [16:0] e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk("resp_id", 32'(id), 32'(e[16]));
            chk("resp_sum", 32'(sum), 32'(e[15:0]));
        end
    endtask

    // Called once per cycle, #1 after the negedge where inputs were driven.
    task automatic sample();
        #1;
        if (r0v && r0r) begin
            sb.push_back({1'b0, 16'(r0a + r0b)});
            gq.push_back(0);
            gc.push_back(cyc);
        end
        if (r1v && r1r) begin
            sb.push_back({1'b1, 16'(r1a + r1b)});
            gq.push_back(1);
            gc.push_back(cyc);
        end
        if (busy) chk("ready_low_when_busy", 32'({r0r, r1r}), 32'd0);
        if (s0v || s1v) chk("resp_onehot", 32'(s0v & s1v), 32'd0);
        if (s1v) s1_seen = 1'b1;
        if (s0v && s0r) pop_resp(1'b0);
        if (s1v && s1r) pop_resp(1'b1);
    endtask

    task automatic adv();
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        int n = 0;
        sample();
        while (sb.size() != 0 && n < 30) begin
            adv();
            sample();
            n++;
        end
        adv();
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        r0v = 1'b1; r1v = 1'b0; s0r = 1'b0; s1r = 1'b0;
        r0a = 16'h0; r0b = 16'h0; r1a = 16'h0; r1b = 16'h0;
        q0v = 1'b0; q1v = 1'b0; qs0r = 1'b0; qs1r = 1'b0; glitch = 1'b0;
        q0a = 16'h0; q0b = 16'h0; q1a = 16'h0; q1b = 16'h0;
        s1_seen = 1'b0;

        // 1. reset with req0_valid held high
        adv();
        for (int i = 0; i < 2; i++) begin
            sample();
            chk("rst_ready0", 32'(r0r), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_add_a", 32'(aa), 32'd0);
            chk("rst_add_b", 32'(ab), 32'd0);
            chk("rst_valids", 32'({s0v, s1v}), 32'd0);
            chk("rst_sum", 32'(sum), 32'd0);
            chk("rst_busy_l4", 32'(qbusy), 32'd0);
            adv();
        end
        rst = 1'b0;

        // 2. single op on requester 0
        s1_seen = 1'b0;
        r0v = 1'b1; r0a = 16'h3E00; r0b = 16'h0200; s0r = 1'b1;
        sample();
        chk("t2_ready_T", 32'(r0r), 32'd1);
        adv();
        r0v = 1'b0;
        sample();
        chk("t2_valid_T1", 32'(s0v), 32'd0);
        adv();
        sample();
        chk("t2_valid_T2", 32'(s0v), 32'd1);
        chk("t2_sum_T2", 32'(sum), 32'h4000);
        adv();
        sample();
        chk("t2_idle_T3", 32'({busy, s0v}), 32'd0);
        adv();
        chk("t2_resp1_never", 32'(s1_seen), 32'd0);

        // 3. tie stream from a fresh reset
        rst = 1'b1;
        sample();
        adv();
        rst = 1'b0;
        sb.delete();
        gq.delete();
        gc.delete();
        r0v = 1'b1; r1v = 1'b1; s0r = 1'b1; s1r = 1'b1;
        n = 0;
        while (gq.size() < 4 && n < 60) begin
            r0a = 16'($urandom); r0b = 16'($urandom);
            r1a = 16'($urandom); r1b = 16'($urandom);
            sample();
            adv();
            n++;
        end
        r0v = 1'b0; r1v = 1'b0;
        chk("tie_accept_count", 32'(gq.size()), 32'd4);
        for (int i = 0; i < gq.size() && i < 4; i++) begin
`ifdef DLF_ARB_FIXED_PRIO_EN
            chk("tie_grant", 32'(gq[i]), 32'd0);
`else
            chk("tie_grant", 32'(gq[i]), 32'(i % 2));
`endif
            if (i > 0) chk("tie_throughput", 32'(gc[i] - gc[i-1]), 32'd3);
        end
        drain();

        // 4. backpressure on requester 1
        s1r = 1'b0;
        r1v = 1'b1; r1a = 16'h1111; r1b = 16'h2222;
        sample();
        chk("bp_accept", 32'(r1r), 32'd1);
        adv();
        r1v = 1'b0;
        r0v = 1'b1; r0a = 16'h0F00; r0b = 16'h0010;
        n = 0;
        sample();
        while (!s1v && n < 10) begin
            adv();
            sample();
            n++;
        end
        chk("bp_valid_arrives", 32'(s1v), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_hold", 32'(s1v), 32'd1);
            chk("bp_sum_hold", 32'(sum), 32'h3333);
            chk("bp_readies_low", 32'({r0r, r1r}), 32'd0);
            adv();
            if (i < 4) sample();
        end
        s1r = 1'b1;
        sample();
        adv();
        n = 0;
        sample();
        while (!r0r && n < 10) begin
            adv();
            sample();
            n++;
        end
        chk("bp_resume", 32'(r0r), 32'd1);
        adv();
        r0v = 1'b0;
        drain();

        // 5. ADD_LAT=4 with a glitching adder until the last WAIT cycle
        q0v = 1'b1; q0a = 16'h1234; q0b = 16'h0101; qs0r = 1'b1; glitch = 1'b1;
        sample();
        chk("l4_ready", 32'(q0r), 32'd1);
        adv();
        q0v = 1'b0;
        for (int i = 0; i < 4; i++) begin
            glitch = (i < 3);
            sample();
            chk("l4_add_a_hold", 32'(qa), 32'h1234);
            chk("l4_add_b_hold", 32'(qb), 32'h0101);
            chk("l4_no_valid_yet", 32'(qs0v), 32'd0);
            adv();
        end
        glitch = 1'b1;
        sample();
        chk("l4_valid", 32'(qs0v), 32'd1);
        chk("l4_sum", 32'(qsum), 32'h1335);
        adv();
        sample();
        chk("l4_done", 32'({qbusy, qs0v}), 32'd0);
        adv();
        glitch = 1'b0;

        // 6a. reset mid-WAIT
        r0v = 1'b1; r0a = 16'h0A00; r0b = 16'h0050; s0r = 1'b1;
        sample();
        adv();
        r0v = 1'b0;
        rst = 1'b1;
        sample();
        chk("rw_in_wait", 32'(busy), 32'd1);
        adv();
        rst = 1'b0;
        sb.delete();
        sample();
        chk("rw_idle", 32'(busy), 32'd0);
        chk("rw_valids", 32'({s0v, s1v}), 32'd0);
        adv();

        // 6b. reset mid-RESP
        r1v = 1'b1; r1a = 16'h0300; r1b = 16'h0030; s1r = 1'b0;
        sample();
        adv();
        r1v = 1'b0;
        sample();
        adv();
        sample();
        chk("rr_in_resp", 32'(s1v), 32'd1);
        rst = 1'b1;
        adv();
        rst = 1'b0;
        sb.delete();
        sample();
        chk("rr_idle", 32'(busy), 32'd0);
        chk("rr_valids", 32'({s0v, s1v}), 32'd0);
        adv();

        // 6c. normal service after reset
        r1v = 1'b1; r1a = 16'h0700; r1b = 16'h0011; s1r = 1'b1;
        sample();
        chk("post_rst_accept", 32'(r1r), 32'd1);
        adv();
        r1v = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
